// File: rtl/fpsr_pkg.sv
// Shared game-timer definitions: timer states, minute limits and quiz defaults.
// Also used by the game-control FSM (MAX_TIME).
package fpsr_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } timer_state_e;

  localparam logic [7:0]  MAX_MINUTES         = 8'd255;
  localparam int unsigned DEFAULT_QUIZ_WINDOW = 10;
  localparam int unsigned MAX_TIME            = 120;

  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] digit);
    return (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/fpsr_game_timer_if.sv
// FSM-flag / timer-output bundle between the game FSM and the game timer.
// The master side is the FSM and display path, the slave side is the timer.
interface fpsr_game_timer_if;

  logic       q_INI;
  logic       q_IDLE;
  logic       q_QUIZ_ANY;
  logic       q_WIN;
  logic       q_LOSE;
  logic [7:0] minutes;
  logic       min_tick;
  logic       running;
  logic [3:0] quiz_left;
  logic       quiz_expired;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;

  modport master (
    output q_INI, q_IDLE, q_QUIZ_ANY, q_WIN, q_LOSE,
    input  minutes, min_tick, running, quiz_left, quiz_expired,
           bcd_hund, bcd_tens, bcd_ones
  );

  modport slave (
    input  q_INI, q_IDLE, q_QUIZ_ANY, q_WIN, q_LOSE,
    output minutes, min_tick, running, quiz_left, quiz_expired,
           bcd_hund, bcd_tens, bcd_ones
  );

endinterface

// File: rtl/fpsr_bcd_counter.sv
// Three-digit BCD incrementer that saturates at 255, kept in lockstep with
// the binary minute counter so the display needs no divider.
module fpsr_bcd_counter
  import fpsr_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  always_comb begin
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    at_max = (hund_q == 4'd2) && (tens_q == 4'd5) && (ones_q == 4'd5);
    if (clear) begin
      hund_d = '0;
      tens_d = '0;
      ones_d = '0;
    end else if (inc && !at_max) begin
      // Ripple the carry only when the lower digit wraps from 9.
      ones_d = bcd_digit_inc(ones_q);
      if (ones_q == 4'd9) begin
        tens_d = bcd_digit_inc(tens_q);
        if (tens_q == 4'd9) begin
          hund_d = hund_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign hund = hund_q;
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/fpsr_game_timer.sv
// Game minute clock with per-quiz countdown, driven by the game FSM's state flags.
// Define FPSR_TIMER_BCD_EN to build the BCD display digits; otherwise they read 0.
module fpsr_game_timer
  import fpsr_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 100000000,
  parameter int unsigned QUIZ_WINDOW   = DEFAULT_QUIZ_WINDOW
) (
  input  logic                Clk,
  input  logic                Reset,
  fpsr_game_timer_if.slave    bus
);

  localparam int unsigned   PW         = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MIN - 1);
  localparam logic [3:0]    QUIZ_LOAD  = 4'(QUIZ_WINDOW);

  timer_state_e  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    minutes_q, minutes_d;
  logic          min_tick_q, min_tick_d;
  logic          running_q, running_d;
  logic [3:0]    quiz_left_q, quiz_left_d;
  logic          quiz_prev_q, quiz_prev_d;
  logic          terminal;
  logic          bcd_clear;
  logic          bcd_inc;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    minutes_d  = minutes_q;
    min_tick_d = 1'b0;
    bcd_clear  = 1'b0;
    bcd_inc    = 1'b0;
    terminal   = (presc_q == PRESC_LAST);

    if (bus.q_INI) begin
      state_d   = ST_STOP;
      presc_d   = '0;
      minutes_d = '0;
      bcd_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          presc_d   = '0;
          minutes_d = '0;
          bcd_clear = 1'b1;
          if (bus.q_IDLE) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Game end wins over a coincident terminal count, so that minute is lost.
          if (bus.q_WIN || bus.q_LOSE) begin
            state_d = ST_FREEZE;
          end else begin
            presc_d = terminal ? '0 : presc_q + PW'(1);
            if (terminal && (minutes_q != MAX_MINUTES)) begin
              minutes_d  = minutes_q + 8'd1;
              min_tick_d = 1'b1;
              bcd_inc    = 1'b1;
            end
          end
        end
        ST_FREEZE: begin
          state_d = ST_FREEZE;
        end
        default: state_d = ST_STOP;
      endcase
    end

    running_d   = (state_d == ST_RUN);
    quiz_prev_d = bus.q_QUIZ_ANY;
    quiz_left_d = quiz_left_q;
    // A fresh quiz load takes precedence over a tick landing in the same cycle.
    if (bus.q_INI || !bus.q_QUIZ_ANY) begin
      quiz_left_d = '0;
    end else if (!quiz_prev_q) begin
      quiz_left_d = QUIZ_LOAD;
    end else if (min_tick_q && (quiz_left_q != 4'd0)) begin
      quiz_left_d = quiz_left_q - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_STOP;
      presc_q     <= '0;
      minutes_q   <= '0;
      min_tick_q  <= 1'b0;
      running_q   <= 1'b0;
      quiz_left_q <= '0;
      quiz_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      minutes_q   <= minutes_d;
      min_tick_q  <= min_tick_d;
      running_q   <= running_d;
      quiz_left_q <= quiz_left_d;
      quiz_prev_q <= quiz_prev_d;
    end
  end

  assign bus.minutes      = minutes_q;
  assign bus.min_tick     = min_tick_q;
  assign bus.running      = running_q;
  assign bus.quiz_left    = quiz_left_q;
  assign bus.quiz_expired = bus.q_QUIZ_ANY && (quiz_left_q == 4'd0);

`ifdef FPSR_TIMER_BCD_EN
  fpsr_bcd_counter u_bcd (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (bcd_clear),
    .inc   (bcd_inc),
    .hund  (bus.bcd_hund),
    .tens  (bus.bcd_tens),
    .ones  (bus.bcd_ones)
  );
`else
  logic unused_bcd_ctrl;
  assign unused_bcd_ctrl = bcd_clear ^ bcd_inc;
  assign bus.bcd_hund    = '0;
  assign bus.bcd_tens    = '0;
  assign bus.bcd_ones    = '0;
`endif

endmodule

// File: tb/tb_fpsr_game_timer.sv
// Self-checking bench for fpsr_game_timer: a minute-count reference model feeds
// a tick scoreboard, while directed and randomized phases check the other outputs.
module tb_fpsr_game_timer;

  localparam int T  = 4;
  localparam int QW = 10;

  logic clk;
  logic rst_n;

  fpsr_game_timer_if bus ();

  fpsr_game_timer #(
    .TICKS_PER_MIN (T),
    .QUIZ_WINDOW   (QW)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int sb_q[$];

  // Reference model: game time is simply the number of counting cycles spent in RUN.
  int     m_state;
  longint m_count;
  bit     m_tick;
  bit     m_prev_tick;
  int     m_ql;
  bit     m_qprev;
  int     exp_m;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_minutes();
    return (m_count / T > 255) ? 255 : int'(m_count / T);
  endfunction

  function automatic logic [11:0] exp_bcd(input int m);
    logic [11:0] d;
    d = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
`ifndef FPSR_TIMER_BCD_EN
    d = '0;
`endif
    return d;
  endfunction

  initial begin
    m_state = 0; m_count = 0; m_tick = 0; m_ql = 0; m_qprev = 0; m_prev_tick = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_count = 0; m_tick = 0; m_ql = 0; m_qprev = 0;
        sb_q.delete();
      end else begin
        m_prev_tick = m_tick;
        m_tick      = 0;
        if (bus.q_INI) begin
          m_state = 0;
          m_count = 0;
        end else if (m_state == 0) begin
          m_count = 0;
          if (bus.q_IDLE) m_state = 1;
        end else if (m_state == 1) begin
          if (bus.q_WIN || bus.q_LOSE) begin
            m_state = 2;
          end else begin
            m_count++;
            if ((m_count % T == 0) && (m_count / T <= 255)) begin
              m_tick = 1;
              sb_q.push_back(int'(m_count / T));
            end
          end
        end
        if (bus.q_INI || !bus.q_QUIZ_ANY) m_ql = 0;
        else if (!m_qprev) m_ql = QW;
        else if (m_prev_tick && m_ql > 0) m_ql = m_ql - 1;
        m_qprev = bus.q_QUIZ_ANY;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.min_tick === 1'b1) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_tick", 32'(bus.min_tick), 32'd0);
          end else begin
            exp_m = sb_q.pop_front();
            check_output("tick_minutes", 32'(bus.minutes), 32'(exp_m));
            check_output("tick_bcd", 32'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 32'(exp_bcd(exp_m)));
          end
        end else if (sb_q.size() != 0) begin
          check_output("missing_tick", 32'(bus.min_tick), 32'd1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic wait_minutes(input int target, input int budget);
    for (int i = 0; i < budget && model_minutes() != target; i++) @(negedge clk);
    check_output("reach_minutes", 32'(bus.minutes), 32'(target));
  endtask

  task automatic wait_terminal(input int target, input int budget);
    for (int i = 0; i < budget && !(model_minutes() == target && m_count % T == T - 1); i++)
      @(negedge clk);
    check_output("terminal_minutes", 32'(bus.minutes), 32'(target));
  endtask

  task automatic restart_run();
    bus.q_INI = 1'b1;
    @(negedge clk);
    bus.q_INI  = 1'b0;
    bus.q_IDLE = 1'b1;
    @(negedge clk);
    bus.q_IDLE = 1'b0;
  endtask

  task automatic apply_stimulus();
    // Reset state
    rst_n = 1'b0;
    bus.q_INI = 1'b1; bus.q_IDLE = 1'b0; bus.q_QUIZ_ANY = 1'b0;
    bus.q_WIN = 1'b0; bus.q_LOSE = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_minutes", 32'(bus.minutes), 32'd0);
    check_output("rst_running", 32'(bus.running), 32'd0);
    check_output("rst_min_tick", 32'(bus.min_tick), 32'd0);
    check_output("rst_quiz_left", 32'(bus.quiz_left), 32'd0);
    check_output("rst_bcd", 32'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First minute after leaving IDLE
    bus.q_INI  = 1'b0;
    bus.q_IDLE = 1'b1;
    @(negedge clk);
    check_output("start_running", 32'(bus.running), 32'd1);
    bus.q_IDLE = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pre_first_minute", 32'(bus.minutes), 32'd0);
    @(negedge clk);
    check_output("first_minute", 32'(bus.minutes), 32'd1);
    check_output("first_tick", 32'(bus.min_tick), 32'd1);
    @(negedge clk);
    check_output("tick_one_cycle", 32'(bus.min_tick), 32'd0);
    repeat (4) @(negedge clk);
    check_output("second_minute", 32'(bus.minutes), 32'd2);

    // BCD mid-range and saturation
    wait_minutes(130, 700);
    check_output("bcd_130", 32'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 32'(exp_bcd(130)));
    wait_minutes(255, 700);
    repeat (40) @(negedge clk);
    check_output("sat_minutes", 32'(bus.minutes), 32'd255);
    check_output("sat_bcd", 32'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 32'(exp_bcd(255)));
    check_output("sat_running", 32'(bus.running), 32'd1);

    // LOSE on a terminal-count cycle discards that minute
    restart_run();
    check_output("ini_clear_minutes", 32'(bus.minutes), 32'd0);
    wait_terminal(42, 400);
    bus.q_LOSE = 1'b1;
    @(negedge clk);
    check_output("freeze_running", 32'(bus.running), 32'd0);
    check_output("freeze_minutes", 32'(bus.minutes), 32'd42);
    check_output("freeze_no_tick", 32'(bus.min_tick), 32'd0);
    repeat ($urandom_range(3, 12)) @(negedge clk);
    bus.q_LOSE = 1'b0;
    repeat (6) @(negedge clk);
    check_output("freeze_hold", 32'(bus.minutes), 32'd42);
    bus.q_INI = 1'b1;
    @(negedge clk);
    bus.q_INI = 1'b0;
    check_output("ini_minutes", 32'(bus.minutes), 32'd0);
    check_output("ini_bcd", 32'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 32'd0);
    check_output("ini_running", 32'(bus.running), 32'd0);

    // Quiz countdown to expiry and clear on exit
    restart_run();
    repeat ($urandom_range(5, 30)) @(negedge clk);
    bus.q_QUIZ_ANY = 1'b1;
    @(negedge clk);
    check_output("quiz_load", 32'(bus.quiz_left), 32'd10);
    check_output("quiz_not_expired", 32'(bus.quiz_expired), 32'd0);
    for (int i = 0; i < 60 && m_ql != 0; i++) @(negedge clk);
    check_output("quiz_zero", 32'(bus.quiz_left), 32'd0);
    check_output("quiz_expired", 32'(bus.quiz_expired), 32'd1);
    repeat (12) @(negedge clk);
    check_output("quiz_floor", 32'(bus.quiz_left), 32'd0);
    check_output("quiz_still_expired", 32'(bus.quiz_expired), 32'd1);
    bus.q_QUIZ_ANY = 1'b0;
    @(negedge clk);
    check_output("quiz_exit_left", 32'(bus.quiz_left), 32'd0);
    check_output("quiz_exit_expired", 32'(bus.quiz_expired), 32'd0);

    // Quiz entry coinciding with a visible min_tick
    for (int i = 0; i < 3 * T && !m_tick; i++) @(negedge clk);
    check_output("coincide_tick", 32'(bus.min_tick), 32'd1);
    bus.q_QUIZ_ANY = 1'b1;
    @(negedge clk);
    check_output("coincide_load", 32'(bus.quiz_left), 32'd10);
    repeat (T + 1) @(negedge clk);
    check_output("coincide_dec", 32'(bus.quiz_left), 32'(m_ql));
    bus.q_QUIZ_ANY = 1'b0;

    // Randomized quiz entry/exit while the clock runs
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) bus.q_QUIZ_ANY = ~bus.q_QUIZ_ANY;
      if (i % 30 == 0) begin
        check_output("rand_minutes", 32'(bus.minutes), 32'(model_minutes()));
        check_output("rand_quiz_left", 32'(bus.quiz_left), 32'(m_ql));
        check_output("rand_expired", 32'(bus.quiz_expired), 32'(bus.q_QUIZ_ANY && m_ql == 0));
        check_output("rand_running", 32'(bus.running), 32'(m_state == 1));
      end
    end
    bus.q_QUIZ_ANY = 1'b0;

    // Asynchronous reset in the middle of a run
    restart_run();
    wait_minutes(77, 400);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_minutes", 32'(bus.minutes), 32'd0);
    check_output("async_running", 32'(bus.running), 32'd0);
    check_output("async_min_tick", 32'(bus.min_tick), 32'd0);
    check_output("async_quiz_left", 32'(bus.quiz_left), 32'd0);
    check_output("async_expired", 32'(bus.quiz_expired), 32'd0);
    check_output("async_bcd", 32'({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_reset_stop", 32'(bus.running), 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fpsr_game_timer.md
Name: fpsr_game_timer

Overview:
- Produces the `minutes` game clock consumed by the game-control FSM.
- Reads back the FSM's one-hot state flags to start, freeze and clear itself.
- Provides a per-quiz countdown and BCD digits of elapsed minutes for the seven-segment display path.
- Sits between the board clock and the game FSM / display mux in the top level.

Parameters:
- TICKS_PER_MIN, 100000000, Clk cycles per game minute (must be >= 1).
- QUIZ_WINDOW, 10, quiz countdown load value in minutes (1..15).

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- q_INI  in  1  FSM in INI.
- q_IDLE  in  1  FSM in IDLE.
- q_QUIZ_ANY  in  1  FSM in QUIZ, QUIZ_1, QUIZ_2 or QUIZ_3 (OR formed at top level).
- q_WIN  in  1  FSM in WIN.
- q_LOSE  in  1  FSM in LOSE.
- minutes  out  8  elapsed game minutes, saturating.
- min_tick  out  1  one-cycle pulse in the cycle minutes increments.
- running  out  1  high while in RUN.
- quiz_left  out  4  minutes remaining in current quiz, 0 outside quiz.
- quiz_expired  out  1  q_QUIZ_ANY & (quiz_left == 0).
- bcd_hund  out  4  hundreds digit of minutes (0..2).
- bcd_tens  out  4  tens digit (0..9).
- bcd_ones  out  4  ones digit (0..9).

Behaviour:
- Reset low (async): state=STOP, prescaler=0, minutes=0, all BCD digits=0, quiz_left=0, min_tick=0, quiz_prev=0.
- States: STOP, RUN, FREEZE. Encoding is internal.
- Priority each cycle: q_INI > (q_WIN|q_LOSE) > normal counting.
- STOP:
  - Clears prescaler and minutes.
  - Goes to RUN when !q_INI & q_IDLE.
- RUN:
  - Prescaler counts 0..TICKS_PER_MIN-1 and wraps to 0.
  - On the terminal count: min_tick=1 next cycle (registered), and minutes increments.
  - Minutes saturates at 255. At 255 the prescaler keeps wrapping, but minutes and BCD hold and min_tick stays 0.
  - q_WIN|q_LOSE -> FREEZE. A terminal count in that same cycle is discarded: no increment, no tick.
  - q_INI -> STOP.
- FREEZE:
  - minutes and BCD hold; prescaler holds.
  - q_INI -> STOP.
- minutes latency: minutes changes on the clock edge after the prescaler terminal count; min_tick is asserted in the same cycle the new value is visible.
- Quiz countdown:
  - quiz_prev registers q_QUIZ_ANY.
  - On the rising edge (q_QUIZ_ANY & !quiz_prev), quiz_left loads QUIZ_WINDOW. The load overrides a coincident min_tick.
  - While q_QUIZ_ANY, each min_tick decrements quiz_left, floored at 0.
  - When !q_QUIZ_ANY, quiz_left=0.
  - quiz_left is ignored in STOP and FREEZE: it is cleared when q_INI is high.
- BCD:
  - Incremental counter updated in lockstep with minutes; no division.
  - ones wraps 9->0 with carry into tens; tens wraps 9->0 with carry into hundreds.
  - Cleared together with minutes.
  - Invariant: 100*hund + 10*tens + ones == minutes at all times.
- Widths: prescaler width = max(1, $clog2(TICKS_PER_MIN)). With TICKS_PER_MIN=1, minutes increments every cycle in RUN.
- Reset mid-count: async clear to the reset values above. The FSM is reset at the same time, so no handshake is needed.

Optional Feature:
- Macro: FPSR_TIMER_BCD_EN.
- Defined: BCD counter logic present; bcd_* behave as above.
- Undefined: no BCD registers; bcd_hund, bcd_tens and bcd_ones are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package fpsr_pkg:
  - Timer state localparams (STOP/RUN/FREEZE).
  - MAX_MINUTES=255.
  - Default QUIZ_WINDOW.
  - MAX_TIME=120, shared with the game FSM.
- One natural sub-module: fpsr_bcd_counter. It is a 3-digit saturating BCD incrementer with clear and inc inputs and the same Clk/Reset. It is instantiated only under FPSR_TIMER_BCD_EN.

Test Plan (TICKS_PER_MIN=4, QUIZ_WINDOW=10):
1. Reset low with q_INI=1, then release. Drive q_INI=0, q_IDLE=1 -> running=1 next cycle; minutes=1 after 4 RUN cycles, then increments every 4 cycles; min_tick is a one-cycle pulse each time.
2. Run to minutes=130 -> bcd_hund=1, bcd_tens=3, bcd_ones=0. Continue to saturation -> minutes stays at 255 (2,5,5) and min_tick stays 0.
3. At minutes=42, assert q_LOSE on a prescaler terminal cycle -> minutes stays 42 and running=0. Then pulse q_INI -> minutes=0 and BCD=0,0,0.
4. Raise q_QUIZ_ANY -> quiz_left=10. After 10 min_ticks -> quiz_left=0 and quiz_expired=1; further ticks keep it at 0. Drop q_QUIZ_ANY -> quiz_left=0 and quiz_expired=0.
5. Raise q_QUIZ_ANY in the same cycle as a min_tick -> quiz_left=10, not 9.
6. Drive Reset low mid-RUN at minutes=77 -> all outputs 0 asynchronously, before the next Clk edge. With FPSR_TIMER_BCD_EN undefined, bcd_* read 0 throughout.
